reg_busif: RTL



---
 rtl/reg_busif_pkg.sv | 32 +++
 rtl/reg_busif_decode.sv | 40 ++++
 rtl/reg_busif.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/reg_busif_pkg.sv
// Shared types and helpers for the reg_busif register-bank initiator.
// The state and error-cause enums are carried on debug outputs so checkers can bind to them.
package reg_busif_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_ALIGN,
        ERR_RANGE,
        ERR_RO,
        ERR_INTG
    } err_cause_e;

    // Widest data path be_to_mask supports; callers cast to and from their own width.
    localparam int unsigned MaxDW = 256;
    localparam int unsigned MaxBE = MaxDW / 8;

    function automatic logic [MaxDW-1:0] be_to_mask(input logic [MaxBE-1:0] be);
        logic [MaxDW-1:0] mask;
        mask = '0;
        for (int unsigned k = 0; k < MaxBE; k++) begin
            mask[k*8 +: 8] = {8{be[k]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/reg_busif_decode.sv
// Address decode for reg_busif: one-hot register select, register index and error cause.
// Purely combinational; sel is all-zero whenever the access is in error.
module reg_busif_decode
    import reg_busif_pkg::*;
#(
    parameter int unsigned        NumRegs = 8,
    parameter int unsigned        AW      = 5,
    parameter logic [NumRegs-1:0] RoMask  = '0
) (
    input  logic [AW-1:0]      addr,
    input  logic               we,
    output logic [NumRegs-1:0] sel,
    output logic [AW-3:0]      idx,
    output err_cause_e         cause
);

    logic [NumRegs-1:0] hit;

    assign idx = addr[AW-1:2];

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            hit[i] = (32'(idx) == i);
        end

        // No hit at all means the index lies beyond the implemented bank.
        cause = ERR_NONE;
        if (addr[1:0] != 2'b00) begin
            cause = ERR_ALIGN;
        end else if (hit == '0) begin
            cause = ERR_RANGE;
        end else if (we && |(hit & RoMask)) begin
            cause = ERR_RO;
        end

        sel = (cause == ERR_NONE) ? hit : '0;
    end

endmodule

// File: rtl/reg_busif.sv
// Bus-side initiator for a bank of sw registers: req/gnt in, one-cycle we/re strobes out, response back.
// Optional write-data parity checking is compiled in with the REG_BUSIF_INTG_EN macro.
module reg_busif
    import reg_busif_pkg::*;
#(
    parameter int unsigned        NumRegs = 8,
    parameter int unsigned        DW      = 32,
    parameter int unsigned        AW      = 5,
    parameter logic [NumRegs-1:0] RoMask  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DW-1:0]         wdata_i,
    input  logic [DW/8-1:0]       be_i,
    input  logic [DW/8-1:0]       wpar_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    input  logic                  rready_i,
    output logic [DW-1:0]         rdata_o,
    output logic                  err_o,
    output logic [NumRegs-1:0]    reg_we_o,
    output logic [NumRegs-1:0]    reg_re_o,
    output logic [DW-1:0]         reg_wd_o,
    input  logic [NumRegs*DW-1:0] reg_qs_i,
    output state_e                dbg_state_o,
    output err_cause_e            dbg_err_cause_o,
    output logic [AW-3:0]         dbg_idx_o
);

    localparam int unsigned NB = DW / 8;

    // Handshakes: a request transfers on a cycle with req_i && gnt_o; a response transfers on a
    // cycle with rvalid_o && rready_i, and rdata_o/err_o stay fixed from rvalid_o rising until then.
    state_e             state_q, state_d;
    logic               we_q;
    logic [AW-1:0]      addr_q;
    logic [DW-1:0]      wdata_q;
    logic [NB-1:0]      be_q;
    logic [DW-1:0]      rdata_q;
    logic               err_q;
    logic [NumRegs-1:0] sel;
    err_cause_e         dec_cause, cause;
    logic               access_ok;
    logic [DW-1:0]      qs_sel, bemask;
    logic               accept;

    reg_busif_decode #(
        .NumRegs (NumRegs),
        .AW      (AW),
        .RoMask  (RoMask)
    ) u_decode (
        .addr  (addr_q),
        .we    (we_q),
        .sel   (sel),
        .idx   (dbg_idx_o),
        .cause (dec_cause)
    );

    assign accept = (state_q == IDLE) && req_i;

`ifdef REG_BUSIF_INTG_EN
    logic [NB-1:0] wpar_q;
    logic          intg_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wpar_q <= '0;
        end else if (accept) begin
            wpar_q <= wpar_i;
        end
    end

    // Every byte is checked, enabled or not, since the whole word crossed the bus.
    always_comb begin
        intg_err = 1'b0;
        for (int unsigned k = 0; k < NB; k++) begin
            if ((^wdata_q[k*8 +: 8]) != wpar_q[k]) intg_err = 1'b1;
        end
        cause = dec_cause;
        if (dec_cause == ERR_NONE && we_q && intg_err) cause = ERR_INTG;
    end
`else
    logic unused_wpar;
    assign unused_wpar = ^wpar_i;
    assign cause       = dec_cause;
`endif

    assign access_ok = (cause == ERR_NONE);
    assign bemask    = DW'(be_to_mask(MaxBE'(be_q)));

    always_comb begin
        qs_sel = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            if (sel[i]) qs_sel = reg_qs_i[i*DW +: DW];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                be_q    <= be_i;
            end
            // Read data is taken in the strobe cycle, i.e. before any read-clear lands.
            if (state_q == ACCESS) begin
                err_q   <= !access_ok;
                rdata_q <= (!we_q && access_ok) ? qs_sel : '0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_o    = 1'b0;
        reg_we_o = '0;
        reg_re_o = '0;
        reg_wd_o = '0;
        unique case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) state_d = ACCESS;
            end
            ACCESS: begin
                if (access_ok) begin
                    if (we_q) begin
                        reg_we_o = sel;
                        reg_wd_o = (wdata_q & bemask) | (qs_sel & ~bemask);
                    end else begin
                        reg_re_o = sel;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                if (rready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rvalid_o        = (state_q == RESP);
    assign rdata_o         = rvalid_o ? rdata_q : '0;
    assign err_o           = rvalid_o & err_q;
    assign dbg_state_o     = state_q;
    assign dbg_err_cause_o = cause;

endmodule
